// File: rtl/seq_mod3_event_monitor_pkg.sv
// Shared types and defaults for the mod-3 event monitor.
// Used by the window timer and the monitor top.
package seq_mod3_event_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ALARM  = 2'd2
    } state_e;

    // Default width of every saturating counter
    localparam int SAT_INC_W   = 8;
    localparam int DEF_WIN_LEN = 16;
    localparam int DEF_THRESH  = 4;

endpackage

// File: rtl/seq_win_timer.sv
// Free-running window position counter, 0..WIN_LEN-1.
// last_cycle marks the final cycle of each back-to-back window.
module seq_win_timer
    import seq_mod3_event_monitor_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int TW      = $clog2(WIN_LEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic last_cycle
);

    localparam logic [TW-1:0] LAST = TW'(WIN_LEN - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next position: hold at 0 when stopped, wrap after the last cycle
    always_comb begin
        cnt_d = cnt_q;
        if (restart || !run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cycle = run && (cnt_q == LAST);

endmodule

// File: rtl/seq_mod3_event_monitor.sv
// Windowed hit/run-length monitor with sticky alarm irq.
// Macro SEQ_MOD3_MAX_RUN_EN enables the max_run tracker.
module seq_mod3_event_monitor
    import seq_mod3_event_monitor_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = SAT_INC_W,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             success,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] total_hits,
    output logic [CNT_W-1:0] win_hits,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic             win_done,
    output logic             win_alarm,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] win_sum;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;
    logic             irq_q, irq_d;
    logic             timer_run;
    logic             last_cycle;

    assign timer_run = (state_q == ST_ACTIVE) || (state_q == ST_ALARM);

    seq_win_timer #(
        .WIN_LEN (WIN_LEN)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (timer_run),
        .restart    (clear || !enable),
        .last_cycle (last_cycle)
    );

    // Window total including this cycle's hit, saturating
    assign win_sum = (acc_q == CNT_MAX) ? acc_q
                   : acc_q + CNT_W'(success);

    // Next state and counters: clear beats disable beats counting
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        win_d   = win_q;
        run_d   = run_q;
        acc_d   = acc_q;
        irq_d   = irq_q;
        done_d  = 1'b0;
        alarm_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            total_d = '0;
            win_d   = '0;
            run_d   = '0;
            acc_d   = '0;
            irq_d   = 1'b0;
        end else if (!enable) begin
            state_d = ST_IDLE;
            run_d   = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ACTIVE;
                ST_ACTIVE, ST_ALARM: begin
                    if (success) begin
                        if (total_q != CNT_MAX) total_d = total_q + 1'b1;
                        if (run_q != CNT_MAX)   run_d   = run_q + 1'b1;
                    end else begin
                        run_d = '0;
                    end
                    if (last_cycle) begin
                        acc_d  = '0;
                        win_d  = win_sum;
                        done_d = 1'b1;
                        if (win_sum >= THR) begin
                            alarm_d = 1'b1;
                            irq_d   = 1'b1;
                            state_d = ST_ALARM;
                        end
                    end else begin
                        acc_d = win_sum;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            total_q <= '0;
            win_q   <= '0;
            run_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            win_q   <= win_d;
            run_q   <= run_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
            irq_q   <= irq_d;
        end
    end

`ifdef SEQ_MOD3_MAX_RUN_EN
    logic [CNT_W-1:0] max_run_q, max_run_d;

    // Track the longest run, one cycle behind run_len
    always_comb begin
        max_run_d = max_run_q;
        if (clear) begin
            max_run_d = '0;
        end else if (run_q > max_run_q) begin
            max_run_d = run_q;
        end
    end

    // Longest-run register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_run_q <= '0;
        end else begin
            max_run_q <= max_run_d;
        end
    end

    assign max_run = max_run_q;
`else
    assign max_run = '0;
`endif

    assign total_hits = total_q;
    assign win_hits   = win_q;
    assign run_len    = run_q;
    assign win_done   = done_q;
    assign win_alarm  = alarm_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_seq_mod3_event_monitor.sv
// Directed table and sequence bench for the event monitor.
// Honours SEQ_MOD3_MAX_RUN_EN for max_run expectations.
module tb_seq_mod3_event_monitor;

`ifdef SEQ_MOD3_MAX_RUN_EN
    localparam int MR_ON = 1;
`else
    localparam int MR_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic success = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;

    logic [7:0] total_hits, win_hits, run_len, max_run;
    logic       win_done, win_alarm, irq;
    logic [3:0] s_total, s_win, s_run, s_max;
    logic       s_done, s_alarm, s_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mod3_event_monitor #(
        .WIN_LEN (16),
        .CNT_W   (8),
        .THRESH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .success    (success),
        .enable     (enable),
        .clear      (clear),
        .total_hits (total_hits),
        .win_hits   (win_hits),
        .run_len    (run_len),
        .max_run    (max_run),
        .win_done   (win_done),
        .win_alarm  (win_alarm),
        .irq        (irq)
    );

    seq_mod3_event_monitor #(
        .WIN_LEN (15),
        .CNT_W   (4),
        .THRESH  (4)
    ) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .success    (success),
        .enable     (enable),
        .clear      (clear),
        .total_hits (s_total),
        .win_hits   (s_win),
        .run_len    (s_run),
        .max_run    (s_max),
        .win_done   (s_done),
        .win_alarm  (s_alarm),
        .irq        (s_irq)
    );

    typedef struct {
        logic en;
        logic clr;
        logic suc;
        int   tot;
        int   run;
        int   done;
        int   alm;
        int   irq;
        int   wh;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rep(input int n, input logic suc, input int tot,
                       input int run, input int irq_e, input int wh);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v = '{1'b1, 1'b0, suc, tot, run, 0, 0, irq_e, wh};
            tbl.push_back(v);
        end
    endtask

    task automatic row(input logic suc, input int tot, input int run,
                       input int done, input int alm, input int irq_e,
                       input int wh);
        vec_t v;
        v = '{1'b1, 1'b0, suc, tot, run, done, alm, irq_e, wh};
        tbl.push_back(v);
    endtask

    initial begin : main
        int nd;
        int exp_run [6];
        logic pat [6];
        exp_run = '{1, 2, 3, 0, 1, 2};
        pat     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // IDLE->ACTIVE, window 1 (hits at 2,5,9)
        row(0, 0, 0, 0, 0, 0, 0);
        rep(2, 0, 0, 0, 0, 0);
        row(1, 1, 1, 0, 0, 0, 0);
        rep(2, 0, 1, 0, 0, 0);
        row(1, 2, 1, 0, 0, 0, 0);
        rep(3, 0, 2, 0, 0, 0);
        row(1, 3, 1, 0, 0, 0, 0);
        rep(5, 0, 3, 0, 0, 0);
        row(0, 3, 0, 1, 0, 0, 3);
        // window 2 (hits at 0,5,10,15) -> alarm
        row(1, 4, 1, 0, 0, 0, 3);
        rep(4, 0, 4, 0, 0, 3);
        row(1, 5, 1, 0, 0, 0, 3);
        rep(4, 0, 5, 0, 0, 3);
        row(1, 6, 1, 0, 0, 0, 3);
        rep(4, 0, 6, 0, 0, 3);
        row(1, 7, 1, 1, 1, 1, 4);

        // reset values
        #3;
        chk("rst.total", int'(total_hits), 0);
        chk("rst.irq", int'(irq), 0);
        chk("rst.done", int'(win_done), 0);
        step();
        rst_n = 1'b1;

        // reset mid-window
        enable = 1'b1;
        step();
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            success = (i < 7);
            step();
            nd += int'(win_done);
        end
        chk("midwin.total", int'(total_hits), 7);
        chk("midwin.run", int'(run_len), 0);
        rst_n = 1'b0;
        #2;
        nd += int'(win_done);
        chk("midwin.nodone", nd, 0);
        chk("midwin.rst.total", int'(total_hits), 0);
        chk("midwin.rst.run", int'(run_len), 0);
        chk("midwin.rst.max", int'(max_run), 0);
        chk("midwin.rst.wh", int'(win_hits), 0);
        enable = 1'b0;
        success = 1'b0;
        step();
        rst_n = 1'b1;

        // table: basic window, alarm on boundary hit
        for (int i = 0; i < tbl.size(); i++) begin
            enable  = tbl[i].en;
            clear   = tbl[i].clr;
            success = tbl[i].suc;
            step();
            chk($sformatf("tbl%0d.total", i), int'(total_hits), tbl[i].tot);
            chk($sformatf("tbl%0d.run", i), int'(run_len), tbl[i].run);
            chk($sformatf("tbl%0d.done", i), int'(win_done), tbl[i].done);
            chk($sformatf("tbl%0d.alarm", i), int'(win_alarm), tbl[i].alm);
            chk($sformatf("tbl%0d.irq", i), int'(irq), tbl[i].irq);
            chk($sformatf("tbl%0d.wh", i), int'(win_hits), tbl[i].wh);
        end

        // zero-hit window keeps irq
        success = 1'b0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            nd += int'(win_done);
        end
        chk("w3.early_done", nd, 0);
        step();
        chk("w3.done", int'(win_done), 1);
        chk("w3.alarm", int'(win_alarm), 0);
        chk("w3.wh", int'(win_hits), 0);
        chk("w3.irq", int'(irq), 1);

        // disable retains irq, IDLE ignores hits
        enable = 1'b0;
        success = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("dis.irq", int'(irq), 1);
        chk("dis.total", int'(total_hits), 7);
        clear = 1'b1;
        step();
        chk("clr.irq", int'(irq), 0);
        chk("clr.total", int'(total_hits), 0);
        chk("clr.wh", int'(win_hits), 0);
        clear = 1'b0;
        step();
        chk("clr.idle_total", int'(total_hits), 0);

        // run lengths
        enable = 1'b1;
        success = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            success = pat[i];
            step();
            chk($sformatf("run%0d", i), int'(run_len), exp_run[i]);
            if (i == 2) chk("run.max_lag", int'(max_run), 2 * MR_ON);
        end
        chk("run.max", int'(max_run), 3 * MR_ON);
        chk("run.total", int'(total_hits), 5);

        // disable mid-window
        clear = 1'b1;
        success = 1'b0;
        step();
        clear = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            success = (i < 2);
            step();
        end
        chk("dA.done", int'(win_done), 1);
        chk("dA.wh", int'(win_hits), 2);
        for (int i = 0; i < 10; i++) begin
            success = (i >= 5);
            step();
        end
        chk("dB.run", int'(run_len), 5);
        enable = 1'b0;
        success = 1'b1;
        step();
        chk("dB.done", int'(win_done), 0);
        chk("dB.wh", int'(win_hits), 2);
        chk("dB.run0", int'(run_len), 0);
        chk("dB.total", int'(total_hits), 7);
        enable = 1'b1;
        success = 1'b0;
        step();
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            nd += int'(win_done);
        end
        chk("reen.early_done", nd, 0);
        step();
        chk("reen.done", int'(win_done), 1);
        chk("reen.wh", int'(win_hits), 0);

        // clear together with a hit
        clear = 1'b1;
        success = 1'b1;
        step();
        chk("clrhit.total", int'(total_hits), 0);
        chk("clrhit.run", int'(run_len), 0);

        // saturation on the narrow instance
        clear = 1'b0;
        success = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            success = 1'b1;
            step();
        end
        chk("sat4.total", int'(s_total), 15);
        chk("sat4.run", int'(s_run), 15);
        chk("sat4.max", int'(s_max), 15 * MR_ON);
        chk("sat8.total", int'(total_hits), 20);
        chk("sat8.run", int'(run_len), 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mod3_event_monitor.md
Name: seq_mod3_event_monitor

Overview:
- Downstream consumer of the serial mod-3 detector's registered `success` output.
- Accumulates detector hits over fixed-length observation windows and tracks consecutive-hit run lengths.
- Raises a sticky interrupt when any window's hit count reaches a threshold.
- Sits between the detector and the status/interrupt logic; all outputs registered.

Parameters:
- WIN_LEN, 16: cycles per observation window; legal range 2..2^CNT_W-1.
- CNT_W, 8: width of all counters and count outputs.
- THRESH, 4: hit count that flags a window as alarmed; 1..WIN_LEN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- success  input  1  per-cycle hit flag from the detector, sampled every rising edge.
- enable  input  1  1 = monitoring active; 0 = idle, window aborted.
- clear  input  1  synchronous clear of all counters, the alarm and irq.
- total_hits  output  CNT_W  saturating count of all hits while active.
- win_hits  output  CNT_W  hit count of the last completed window.
- run_len  output  CNT_W  current consecutive-hit run length, saturating.
- max_run  output  CNT_W  longest run since reset/clear.
- win_done  output  1  one-cycle pulse when a window completes.
- win_alarm  output  1  one-cycle pulse, coincident with win_done, when the completed window has hits >= THRESH.
- irq  output  1  sticky; set with win_alarm, cleared only by clear or reset.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all counters, outputs and internal registers = 0.
- States:
  - IDLE: entered from reset. enable=1 -> ACTIVE next edge.
  - ACTIVE: enable=0 -> IDLE. Any window with hits >= THRESH -> ALARM.
  - ALARM: behaves as ACTIVE with irq held 1. enable=0 -> IDLE with irq retained. Only clear returns to IDLE and drops irq.
- Priority per edge: clear > enable=0 > normal counting.
- clear=1: all counters, win_hits, max_run and irq go to 0 at that edge, and state goes to IDLE. The success sampled in that cycle is discarded.
- Window timer:
  - Counts 0..WIN_LEN-1 while in ACTIVE/ALARM, starting at 0 on the first active cycle.
  - In the cycle where the timer is WIN_LEN-1, the window accumulator plus that cycle's success is latched into win_hits and win_done=1 on the following cycle.
  - On that same edge the accumulator and timer restart at 0, so windows are back-to-back with no gap cycle.
- Alarm: win_alarm = 1 in the same cycle as win_done iff the latched count >= THRESH. irq rises with it.
- Disable mid-window: timer and accumulator reset to 0, no win_done. win_hits keeps its previous value; run_len resets to 0.
- run_len:
  - Increments on each success=1, resets to 0 on success=0.
  - max_run updates when the new run_len exceeds it; update latency 1 cycle after run_len.
- Saturation: total_hits, run_len and the window accumulator hold at 2^CNT_W-1, with no wrap.
- Latency: success at edge N is reflected in total_hits/run_len after edge N, i.e. visible in cycle N+1.
- Hits are counted only in ACTIVE/ALARM; success is ignored in IDLE.

Optional Feature:
- SEQ_MOD3_MAX_RUN_EN defined: max_run register and compare logic are present as described.
- Not defined: max_run tied to 0, and the run-length compare logic is removed. run_len is unaffected.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ACTIVE=2'd1, ALARM=2'd2), a saturating-increment width constant, default WIN_LEN/THRESH values.
- One sub-module: seq_win_timer.
  - Parameterised WIN_LEN.
  - Inputs: clk, rst_n, run, restart.
  - Output: last_cycle flag.
  - Reused by later windowed monitors.

Test Plan:
- Reset mid-window: enable=1, 7 hits over 10 cycles, pulse rst_n low -> all outputs 0 immediately; win_done never asserted.
- Basic window: WIN_LEN=16, THRESH=4, enable=1, success=1 on cycles 2,5,9 -> win_done pulse at cycle 16, win_hits=3, win_alarm=0, irq=0, total_hits=3.
- Alarm, boundary hit, sticky irq: 4 hits in a window including cycle 15 (last cycle) -> win_hits=4, win_alarm=1 for one cycle, irq=1. irq stays 1 through later zero-hit windows and through enable=0. clear=1 -> irq=0, state IDLE.
- Runs: success pattern 1,1,1,0,1,1 -> run_len sequence 1,2,3,0,1,2; max_run=3. With SEQ_MOD3_MAX_RUN_EN undefined, max_run=0 throughout.
- Saturation: CNT_W=4, 20 consecutive hits -> total_hits and run_len hold at 15.
- Disable and simultaneous events: drop enable at timer=10 with 5 hits -> no win_done, win_hits unchanged, run_len=0. Re-enable -> new window of a full 16 cycles. clear asserted together with success=1 -> total_hits=0.
